vga_src_select: RTL and testbench

//  Parametrised N-way pixel-source selector for the VGA pipeline; successor to the 2:1 colour mux.

---
 rtl/vga_src_select.sv | 121 ++++++++++++
 tb/tb_vga_src_select.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_src_select.sv
// N-way RGB source selector; source switches are requested by handshake and applied at frame_start.
// Optional macro SRC_SEL_BLANK_EN mutes the output for the whole first frame after a switch.
module vga_src_select #(
  parameter int WIDTH = 12,
  parameter int N_SRC = 4,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC*WIDTH-1:0] data_in,
  input  logic                   de_in,
  input  logic                   frame_start,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  output logic [SEL_W-1:0]       cur_sel,
  output logic                   switched,
  output logic [WIDTH-1:0]       data_out,
  output logic                   de_out
);

  localparam int                N_SLOT  = 2 ** SEL_W;
  localparam logic [SEL_W:0]    N_SRC_W = (SEL_W + 1)'(N_SRC);
  localparam logic [SEL_W-1:0]  MAX_SEL = SEL_W'(N_SRC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    MUTE    = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] cur_sel_reg, pend_sel_reg;
  logic [SEL_W-1:0] next_sel, clamped_sel;
  logic [WIDTH-1:0] data_out_reg;
  logic             de_out_reg, switched_reg;
  logic             accept, apply, blank;

  // Unpack into a power-of-two table so any SEL_W index is in range; unused slots read as zero.
  logic [WIDTH-1:0] src [N_SLOT];

  generate
    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_src
      if (gi < N_SRC) begin : g_used
        assign src[gi] = data_in[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign src[gi] = '0;
      end
    end
  endgenerate

  assign clamped_sel = ({1'b0, sel_in} >= N_SRC_W) ? MAX_SEL : sel_in;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    apply      = 1'b0;
    blank      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          accept     = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          apply = 1'b1;
`ifdef SRC_SEL_BLANK_EN
          // The first pixel of the new frame is already part of the muted frame.
          blank      = 1'b1;
          state_next = MUTE;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef SRC_SEL_BLANK_EN
      MUTE: begin
        if (frame_start) begin
          state_next = IDLE;
        end else begin
          blank = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign next_sel = apply ? pend_sel_reg : cur_sel_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cur_sel_reg  <= '0;
      pend_sel_reg <= '0;
      data_out_reg <= '0;
      de_out_reg   <= 1'b0;
      switched_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        pend_sel_reg <= clamped_sel;
      end
      if (apply) begin
        cur_sel_reg <= pend_sel_reg;
      end
      switched_reg <= apply;
      de_out_reg   <= de_in;
      data_out_reg <= (de_in && !blank) ? src[next_sel] : '0;
    end
  end

  assign sel_ready = (state_reg == IDLE);
  assign cur_sel   = cur_sel_reg;
  assign switched  = switched_reg;
  assign data_out  = data_out_reg;
  assign de_out    = de_out_reg;

endmodule

// File: tb/tb_vga_src_select.sv
// Directed bench for vga_src_select: a 4-source instance plus a 3-source instance for clamping.
module tb_vga_src_select;

`ifdef SRC_SEL_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] data_in;
  logic        de_in;
  logic        frame_start;
  logic [1:0]  sel_in;
  logic        sel_valid;
  logic        sel_ready;
  logic [1:0]  cur_sel;
  logic        switched;
  logic [11:0] data_out;
  logic        de_out;

  logic [35:0] data_in3;
  logic [1:0]  sel_in3;
  logic        sel_valid3;
  logic        sel_ready3;
  logic [1:0]  cur_sel3;
  logic        switched3;
  logic [11:0] data_out3;
  logic        de_out3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_src_select #(.WIDTH(12), .N_SRC(4)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .de_in(de_in),
    .frame_start(frame_start), .sel_in(sel_in), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .cur_sel(cur_sel), .switched(switched),
    .data_out(data_out), .de_out(de_out)
  );

  vga_src_select #(.WIDTH(12), .N_SRC(3)) u_dut3 (
    .clk(clk), .reset(reset), .data_in(data_in3), .de_in(de_in),
    .frame_start(frame_start), .sel_in(sel_in3), .sel_valid(sel_valid3),
    .sel_ready(sel_ready3), .cur_sel(cur_sel3), .switched(switched3),
    .data_out(data_out3), .de_out(de_out3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // With muting enabled, one more frame boundary is needed before output resumes.
  task automatic leave_mute();
    if (BLANK) frame_pulse();
  endtask

  initial begin
    reset       = 1'b1;
    de_in       = 1'b1;
    frame_start = 1'b0;
    sel_in      = 2'd0;
    sel_valid   = 1'b0;
    sel_in3     = 2'd0;
    sel_valid3  = 1'b0;
    data_in     = {4{12'hFFF}};
    data_in3    = {12'h333, 12'h222, 12'h111};
    @(negedge clk);

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_cur_sel", 32'(cur_sel), 32'h0);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_de_out", 32'(de_out), 32'h0);
    end
    reset = 1'b0;
    tick();
    check("post_rst_data", 32'(data_out), 32'hFFF);
    check("post_rst_ready", 32'(sel_ready), 32'h1);
    check("post_rst_de", 32'(de_out), 32'h1);

    // Basic switch to source 2, mid-frame request
    data_in = {12'h400, 12'h300, 12'h200, 12'h100};
    tick();
    check("src0_data", 32'(data_out), 32'h100);
    sel_in = 2'd2; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    check("pend_ready", 32'(sel_ready), 32'h0);
    check("pend_cur_sel", 32'(cur_sel), 32'h0);
    tick(); tick();
    check("pend_data_hold", 32'(data_out), 32'h100);
    check("pend_switched", 32'(switched), 32'h0);
    frame_pulse();
    check("apply_switched", 32'(switched), 32'h1);
    check("apply_cur_sel", 32'(cur_sel), 32'h2);
    check("apply_data", 32'(data_out), BLANK ? 32'h0 : 32'h300);
    tick();
    check("switched_pulse_end", 32'(switched), 32'h0);
    leave_mute();
    check("src2_data", 32'(data_out), 32'h300);
    check("idle_ready", 32'(sel_ready), 32'h1);

    // Request coincident with frame_start waits for the next boundary
    sel_in = 2'd3; sel_valid = 1'b1; frame_start = 1'b1;
    tick();
    sel_valid = 1'b0; frame_start = 1'b0;
    check("coinc_switched", 32'(switched), 32'h0);
    check("coinc_cur_sel", 32'(cur_sel), 32'h2);
    check("coinc_ready", 32'(sel_ready), 32'h0);
    tick();
    check("coinc_data_hold", 32'(data_out), 32'h300);
    frame_pulse();
    check("coinc_apply_sel", 32'(cur_sel), 32'h3);
    check("coinc_apply_sw", 32'(switched), 32'h1);
    tick();
    leave_mute();
    check("src3_data", 32'(data_out), 32'h400);

    // First request wins while pending; clamp on the 3-source instance
    sel_in = 2'd1; sel_valid = 1'b1;
    sel_in3 = 2'd3; sel_valid3 = 1'b1;
    tick();
    sel_valid3 = 1'b0;
    sel_in = 2'd3;
    tick();
    sel_valid = 1'b0;
    frame_pulse();
    check("first_wins_sel", 32'(cur_sel), 32'h1);
    check("clamp_sel", 32'(cur_sel3), 32'h2);
    check("clamp_switched", 32'(switched3), 32'h1);
    tick();
    leave_mute();
    check("src1_data", 32'(data_out), 32'h200);
    check("clamp_data", 32'(data_out3), 32'h333);

    // Requesting the current index still completes and pulses switched
    sel_in = 2'd1; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    check("same_ready", 32'(sel_ready), 32'h0);
    frame_pulse();
    check("same_switched", 32'(switched), 32'h1);
    check("same_cur_sel", 32'(cur_sel), 32'h1);
    tick();
    leave_mute();

    // Back to source 0, then frame_start while idle does nothing
    sel_in = 2'd0; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    frame_pulse();
    tick();
    leave_mute();
    frame_pulse();
    check("idle_fs_switched", 32'(switched), 32'h0);
    check("idle_fs_cur_sel", 32'(cur_sel), 32'h0);
    check("idle_fs_ready", 32'(sel_ready), 32'h1);

    // Blanking by de_in
    data_in = {12'h400, 12'h300, 12'h200, 12'hABC};
    de_in = 1'b0;
    tick();
    check("blank_data", 32'(data_out), 32'h0);
    check("blank_de", 32'(de_out), 32'h0);
    de_in = 1'b1;
    tick();
    check("unblank_data", 32'(data_out), 32'hABC);
    check("unblank_de", 32'(de_out), 32'h1);

    // Mute behaviour after switching to source 1
    data_in = {12'h400, 12'h300, 12'h200, 12'h100};
    sel_in = 2'd1; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    frame_pulse();
    check("mute_apply_data", 32'(data_out), BLANK ? 32'h0 : 32'h200);
    tick(); tick();
    check("mute_frame_data", 32'(data_out), BLANK ? 32'h0 : 32'h200);
    check("mute_frame_ready", 32'(sel_ready), BLANK ? 32'h0 : 32'h1);
    check("mute_frame_de", 32'(de_out), 32'h1);
    frame_pulse();
    check("mute_exit_data", 32'(data_out), 32'h200);
    check("mute_exit_ready", 32'(sel_ready), 32'h1);

    // Reset while pending discards the request
    sel_in = 2'd3; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_pend_ready", 32'(sel_ready), 32'h1);
    check("rst_pend_cur_sel", 32'(cur_sel), 32'h0);
    frame_pulse();
    check("rst_pend_no_sw", 32'(switched), 32'h0);
    check("rst_pend_data", 32'(data_out), 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
